// File: rtl/image_streamer.sv
// Frame buffer that replays a stored image as gap-free beats, optionally repeating it
// with a fixed idle gap between frames.
module image_streamer #(
    parameter int unsigned NO_CH         = 2,
    parameter int unsigned LOG2_IMG_SIZE = 10,
    parameter int unsigned THROUGHPUT    = 1,
    parameter int unsigned GAP           = 2,
    parameter int unsigned FRM_W         = 8,
    localparam int unsigned DEPTH  = 2 ** (LOG2_IMG_SIZE - $clog2(THROUGHPUT)),
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned DATA_W = NO_CH * THROUGHPUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [FRM_W-1:0]  frames,
    output logic              ready,
    output logic              done,
    output logic              wr_err,
    output logic              vld_out,
    output logic [DATA_W-1:0] data_out
);

    localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [GapW-1:0]   GapLast  = GapW'(GAP - 1);

    typedef enum logic [1:0] {StIdle, StStream, StGap} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [FRM_W-1:0]  frm_left_q, frm_left_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic              iss_vld_q, iss_vld_d;
    logic              iss_last_q, iss_last_d;
    logic [ADDR_W-1:0] iss_addr_q;
    logic              out_last_q;
    logic              vld_q;
    logic              done_q;
    logic              wr_err_q, wr_err_d;
    logic [DATA_W-1:0] data_q;

    // Sized to the full address range so a 1-beat frame never indexes out of bounds.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Ready waits for the read pipeline to drain so done and ready rise together.
    assign ready    = (state_q == StIdle) && !iss_vld_q && !vld_q;
    assign done     = done_q;
    assign wr_err   = wr_err_q;
    assign vld_out  = vld_q;
    assign data_out = data_q;

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        frm_left_d = frm_left_q;
        gap_cnt_d  = gap_cnt_q;
        iss_vld_d  = 1'b0;
        iss_last_d = 1'b0;
        wr_err_d   = wr_err_q;

        unique case (state_q)
            StIdle: begin
                if (start && ready) begin
                    frm_left_d = (frames == '0) ? FRM_W'(1) : frames;
                    rd_addr_d  = '0;
                    wr_err_d   = 1'b0;
                    state_d    = StStream;
                end
            end
            StStream: begin
                iss_vld_d = 1'b1;
                rd_addr_d = rd_addr_q + 1'b1;
                if (rd_addr_q == LastAddr) begin
                    if (frm_left_q > FRM_W'(1)) begin
                        frm_left_d = frm_left_q - 1'b1;
                        gap_cnt_d  = '0;
                        state_d    = StGap;
                    end else begin
                        iss_last_d = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    gap_cnt_d = '0;
                    rd_addr_d = '0;
                    state_d   = StStream;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr_en && (state_q != StIdle)) begin
            wr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            rd_addr_q  <= '0;
            frm_left_q <= '0;
            gap_cnt_q  <= '0;
            iss_vld_q  <= 1'b0;
            iss_last_q <= 1'b0;
            iss_addr_q <= '0;
            out_last_q <= 1'b0;
            vld_q      <= 1'b0;
            done_q     <= 1'b0;
            wr_err_q   <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            frm_left_q <= frm_left_d;
            gap_cnt_q  <= gap_cnt_d;
            iss_vld_q  <= iss_vld_d;
            iss_last_q <= iss_last_d;
            iss_addr_q <= rd_addr_q;
            out_last_q <= iss_vld_q && iss_last_q;
            vld_q      <= iss_vld_q;
            done_q     <= out_last_q;
            wr_err_q   <= wr_err_d;
            if (iss_vld_q) begin
                data_q <= mem[iss_addr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && (state_q == StIdle)) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer: a 4-beat configuration and a 1-beat (THROUGHPUT=8) one.
module tb_image_streamer;

    logic        clk;
    logic        rst;

    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        start;
    logic [7:0]  frames;
    logic        ready, done, wr_err, vld_out;
    logic [3:0]  data_out;

    logic        wr_en8;
    logic [0:0]  wr_addr8;
    logic [15:0] wr_data8;
    logic        start8;
    logic [7:0]  frames8;
    logic        ready8, done8, wr_err8, vld8;
    logic [15:0] data8;

    int          tests;
    int          fails;
    logic [31:0] vmask;
    logic [31:0] dmask;
    logic [15:0] cap [32];

    image_streamer #(
        .NO_CH(2), .LOG2_IMG_SIZE(3), .THROUGHPUT(2), .GAP(2), .FRM_W(8)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .frames(frames), .ready(ready), .done(done), .wr_err(wr_err),
        .vld_out(vld_out), .data_out(data_out)
    );

    image_streamer #(
        .NO_CH(2), .LOG2_IMG_SIZE(3), .THROUGHPUT(8), .GAP(2), .FRM_W(8)
    ) dut8 (
        .clk(clk), .rst(rst), .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
        .start(start8), .frames(frames8), .ready(ready8), .done(done8), .wr_err(wr_err8),
        .vld_out(vld8), .data_out(data8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // The tick inside is the start edge E; capture() then records edges E+1..E+n.
    task automatic go(input logic [7:0] f);
        frames = f;
        start  = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic capture(input bit sel, input int n, input int start_k, input int wr_k);
        vmask = '0;
        dmask = '0;
        for (int k = 1; k <= n; k++) begin
            start = (k == start_k);
            if (k == wr_k) begin
                wr_en   = 1'b1;
                wr_addr = 2'd1;
                wr_data = 4'h7;
            end
            tick();
            start = 1'b0;
            wr_en = 1'b0;
            if (sel) begin
                vmask[k] = vld8;
                dmask[k] = done8;
                cap[k]   = data8;
            end else begin
                vmask[k] = vld_out;
                dmask[k] = done;
                cap[k]   = {12'h000, data_out};
            end
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        start    = 1'b0;
        frames   = '0;
        wr_en8   = 1'b0;
        wr_addr8 = '0;
        wr_data8 = '0;
        start8   = 1'b0;
        frames8  = '0;

        #2;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wr_err", {31'd0, wr_err}, 32'd0);
        chk("rst_vld", {31'd0, vld_out}, 32'd0);
        chk("rst_data", {28'd0, data_out}, 32'd0);
        chk("rst_ready8", {31'd0, ready8}, 32'd1);
        #10 rst = 1'b1;
        tick();

        // Image {lane1,lane0}: {0,1},{2,3},{0,1},{3,2}
        wr(2'd0, 4'h1);
        wr(2'd1, 4'hB);
        wr(2'd2, 4'h1);
        wr(2'd3, 4'hE);

        // Single frame
        go(8'd1);
        chk("s1_ready_busy", {31'd0, ready}, 32'd0);
        capture(1'b0, 8, 0, 0);
        chk("s1_vld_mask", vmask, 32'h0000_003C);
        chk("s1_done_mask", dmask, 32'h0000_0040);
        chk("s1_beat0", {16'd0, cap[2]}, 32'h1);
        chk("s1_beat1", {16'd0, cap[3]}, 32'hB);
        chk("s1_beat2", {16'd0, cap[4]}, 32'h1);
        chk("s1_beat3", {16'd0, cap[5]}, 32'hE);
        chk("s1_hold", {16'd0, cap[6]}, 32'hE);
        chk("s1_ready_after", {31'd0, ready}, 32'd1);

        // Three repeats with 2-cycle gaps
        go(8'd3);
        capture(1'b0, 22, 0, 0);
        chk("s2_vld_mask", vmask, 32'h0003_CF3C);
        chk("s2_done_mask", dmask, 32'h0004_0000);
        chk("s2_f2_beat0", {16'd0, cap[8]}, 32'h1);
        chk("s2_f2_beat3", {16'd0, cap[11]}, 32'hE);
        chk("s2_f3_beat1", {16'd0, cap[15]}, 32'hB);
        chk("s2_gap_hold", {16'd0, cap[13]}, 32'hE);

        // frames=0 acts as 1; start during STREAM ignored
        go(8'd0);
        capture(1'b0, 10, 2, 0);
        chk("s3_vld_mask", vmask, 32'h0000_003C);
        chk("s3_done_mask", dmask, 32'h0000_0040);
        chk("s3_beat2", {16'd0, cap[4]}, 32'h1);

        // Write during STREAM is dropped and flagged
        go(8'd1);
        capture(1'b0, 8, 0, 3);
        chk("s4_vld_mask", vmask, 32'h0000_003C);
        chk("s4_beat1", {16'd0, cap[3]}, 32'hB);
        chk("s4_wr_err_sticky", {31'd0, wr_err}, 32'd1);
        go(8'd1);
        chk("s4_wr_err_clear", {31'd0, wr_err}, 32'd0);
        capture(1'b0, 8, 0, 0);
        chk("s4_replay_beat1", {16'd0, cap[3]}, 32'hB);
        chk("s4_replay_mask", vmask, 32'h0000_003C);

        // Async reset during beat 2
        go(8'd1);
        capture(1'b0, 3, 0, 0);
        chk("s5_beat2_live", {31'd0, vmask[3]}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("s5_vld_dropped", {31'd0, vld_out}, 32'd0);
        chk("s5_ready_in_rst", {31'd0, ready}, 32'd1);
        #3 rst = 1'b1;
        capture(1'b0, 4, 0, 0);
        chk("s5_no_vld", vmask, 32'd0);
        chk("s5_no_done", dmask, 32'd0);
        chk("s5_ready_after", {31'd0, ready}, 32'd1);
        go(8'd1);
        capture(1'b0, 8, 0, 0);
        chk("s5_replay_mask", vmask, 32'h0000_003C);
        chk("s5_replay_b0", {16'd0, cap[2]}, 32'h1);
        chk("s5_replay_b1", {16'd0, cap[3]}, 32'hB);
        chk("s5_replay_b3", {16'd0, cap[5]}, 32'hE);

        // DEPTH=1 configuration, two frames
        wr_en8   = 1'b1;
        wr_addr8 = 1'b0;
        wr_data8 = 16'hA5C3;
        tick();
        wr_en8  = 1'b0;
        frames8 = 8'd2;
        start8  = 1'b1;
        tick();
        start8 = 1'b0;
        capture(1'b1, 8, 0, 0);
        chk("s6_vld_mask", vmask, 32'h0000_0024);
        chk("s6_done_mask", dmask, 32'h0000_0040);
        chk("s6_pulse0", {16'd0, cap[2]}, 32'hA5C3);
        chk("s6_pulse1", {16'd0, cap[5]}, 32'hA5C3);
        chk("s6_ready", {31'd0, ready8}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/image_streamer.md
Name: image_streamer

Overview:
- Frame source for the convolution windowing stage.
- Buffers one image written by the host or control path, then on command replays it as a contiguous, gap-free burst of THROUGHPUT samples per cycle. The burst carries no back-pressure.
- Supports back-to-back replays of the same frame, with an enforced idle gap so the downstream windower finishes its zero-padding flush before the next frame starts.

Parameters:
- NO_CH, 2, bits per sample.
- LOG2_IMG_SIZE, 10, log2 of samples per frame.
- THROUGHPUT, 1, samples per beat; power of 2, ≤ 2^LOG2_IMG_SIZE.
- GAP, 2, idle cycles (vld_out=0) between consecutive frames; ≥1.
- FRM_W, 8, width of the frame-repeat count.
- Derived: DEPTH = 2^(LOG2_IMG_SIZE - log2(THROUGHPUT)) beats per frame; ADDR_W = log2(DEPTH), minimum 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  ADDR_W  beat address.
- wr_data  in  [NO_CH-1:0] x [THROUGHPUT-1:0]  one beat.
- start  in  1  replay request; sampled only when ready=1.
- frames  in  FRM_W  replay count, latched with start; 0 is treated as 1.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse after the last beat of the last frame.
- wr_err  out  1  sticky flag: a write was attempted while not IDLE.
- vld_out  out  1  beat valid.
- data_out  out  [NO_CH-1:0] x [THROUGHPUT-1:0]  beat; lane k holds sample addr*THROUGHPUT + (THROUGHPUT-1-k), so the highest lane is the earliest sample.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ready=1; done=0; wr_err=0; vld_out=0; data_out=0; counters=0.
  - Buffer contents are not cleared.
  - Reset mid-frame drops vld_out immediately and truncates the frame; no done is generated.
- Buffer:
  - DEPTH x (NO_CH*THROUGHPUT) RAM, synchronous write, synchronous 1-cycle read.
  - Writes are accepted only in IDLE.
  - wr_en in STREAM or GAP is dropped and sets wr_err. wr_err clears on the next accepted start.
- FSM states: IDLE, STREAM, GAP.
  - IDLE: ready=1. start=1 → latch frames (0→1) into frm_left, rd_addr=0, go to STREAM.
    - A wr_en in the same cycle as start is committed first and is visible in the replay.
  - STREAM: issue rd_addr each cycle and increment it.
    - After issuing DEPTH-1: if frm_left>1, decrement it and go to GAP; otherwise go to IDLE.
  - GAP: gap_cnt counts GAP cycles, then rd_addr=0 and return to STREAM.
  - start outside IDLE is ignored.
- Output pipeline:
  - rd_addr issue is registered, then RAM read: 2 cycles total.
  - start sampled at edge E → vld_out=1 from edge E+2 for exactly DEPTH consecutive cycles with data in address order 0..DEPTH-1.
  - Between frames: exactly GAP cycles with vld_out=0.
  - When vld_out=0, data_out holds its last value (not zeroed).
- done:
  - Asserted for one cycle, on the cycle immediately after the final vld_out beat.
  - ready rises on the same cycle, so vld_out and done are never both 1.
  - start may be accepted on the cycle ready rises. The next frame's first vld_out then follows 2 cycles later, giving at least 2 idle cycles between runs.
- Wrap-around: rd_addr is ADDR_W bits and wraps naturally; the end-of-frame compare is on DEPTH-1, never on overflow.
- DEPTH=1 (THROUGHPUT = 2^LOG2_IMG_SIZE): STREAM lasts one cycle per frame; vld_out is a 1-cycle pulse per frame.

Test Plan:
- Setup for all scenarios: LOG2_IMG_SIZE=3, THROUGHPUT=2, NO_CH=2, GAP=2 (DEPTH=4).
- Single frame: write beats addr0..3 = {lane1,lane0}={0,1},{2,3},{0,1},{3,2}; start with frames=1 at edge E.
  - vld_out high edges E+2..E+5 with data in that order.
  - done=1 at E+6; ready=1 from E+6.
- Repeat: same image, frames=3.
  - Three 4-beat bursts, each separated by exactly 2 vld_out=0 cycles; 16 total cycles.
  - done once, after beat 12.
- frames=0 behaves identically to frames=1; a start pulse during STREAM is ignored (still 4 beats, one done).
- wr_en to addr 1 during STREAM: frame data is unchanged, wr_err=1 and stays high. The next start clears wr_err, and the replay shows the original addr-1 data.
- Async reset asserted during beat 2: vld_out=0 immediately and ready=1 after release. A fresh start replays the original image intact (buffer preserved).
- THROUGHPUT=8 (DEPTH=1), frames=2: single-cycle vld_out pulses separated by 2 idle cycles; done after the second pulse.
